// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the USB PLL supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } sup_state_t;

  localparam int unsigned LOST_W = 8;
  localparam logic [LOST_W-1:0] LOST_SAT = 8'hFF;

  // Increment that sticks at the all-ones value.
  function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
    return (v == LOST_SAT) ? v : v + LOST_W'(1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Generic two-flop synchroniser for asynchronous status inputs.
module pll_lock_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out
);

  logic [W-1:0] meta;

  // Two register stages; both clear on reset so status reads as inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_usb_supervisor.sv
// Sequences the USB PLL reset, qualifies lock and gates the USB-domain reset.
module pll_usb_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 5000,
  parameter int unsigned SETTLE_CYCLES = 500,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 13
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic              usb_rst,
  output logic              ready,
  output logic              fault,
  output logic [1:0]        retry_count,
  output logic [LOST_W-1:0] lost_count
);

  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST  = 2'(MAX_RETRIES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  sup_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        retry_nxt;
  logic [LOST_W-1:0] lost_nxt;
  logic              sync_locked;
  logic              fail;

  pll_lock_sync #(
    .W (1)
  ) u_lock_sync (
    .clk      (refclk),
    .rst      (rst),
    .async_in (pll_locked),
    .sync_out (sync_locked)
  );

  // Next-state, counter and status counters; relock_req overrides all.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_count;
    lost_nxt  = lost_count;
    fail      = 1'b0;
    if (relock_req) begin
      state_nxt = RESET;
      cnt_nxt   = RST_LOAD;
      retry_nxt = '0;
    end else begin
      unique case (state)
        RESET: begin
          if (cnt == '0) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = LOCK_LOAD;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (sync_locked) begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end else if (cnt == '0) begin
            fail = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (!sync_locked) begin
            fail = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        RUN: begin
          if (!sync_locked) begin
            state_nxt = RESET;
            cnt_nxt   = RST_LOAD;
            lost_nxt  = sat_inc(lost_count);
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = RESET;
          cnt_nxt   = RST_LOAD;
        end
      endcase

      // Failures from WAIT_LOCK and SETTLE share one retry/fault decision.
      if (fail) begin
        if (retry_count == RETRY_LAST) begin
          state_nxt = FAULT;
          retry_nxt = RETRY_MAX;
        end else begin
          state_nxt = RESET;
          cnt_nxt   = RST_LOAD;
          retry_nxt = retry_count + 2'd1;
        end
      end
    end
  end

  // State, counters and outputs; outputs decode next-state so they move with it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= RESET;
      cnt         <= RST_LOAD;
      retry_count <= '0;
      lost_count  <= '0;
      pll_rst     <= 1'b1;
      usb_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      lost_count  <= lost_nxt;
      pll_rst     <= (state_nxt == RESET) || (state_nxt == FAULT);
      usb_rst     <= (state_nxt != RUN);
      ready       <= (state_nxt == RUN);
      fault       <= (state_nxt == FAULT);
    end
  end

endmodule
